// File: rtl/crc_job_sequencer.sv
// Drives one CRC job over AXI-Lite: INIT_VALUE to 0x00, each data word to 0x04, result read from 0x08.
// Latency: about 3 cycles per write plus slave delays; the result is held until res_ready.
// Backpressure: in_ready is high only in DATA_GET. Define CRC_SEQ_TIMEOUT_EN to enable the 255-cycle AXI timeout.
module crc_job_sequencer #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] INIT_VALUE = 32'hFFFF_FFFF
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  job_start,
    input  logic [7:0]            job_len,
    output logic                  job_busy,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  res_valid,
    output logic [31:0]           res_crc,
    output logic [1:0]            res_resp,
    input  logic                  res_ready,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [31:0]           m_wdata,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    input  logic                  m_rvalid,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_rready
);

    typedef enum logic [2:0] {IDLE, INIT_WR, DATA_GET, DATA_WR, RES_RD, RES_OUT} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RES  = ADDR_WIDTH'(8'h08);

    state_t     state;
    logic [7:0] word_cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, in_hs, last_write;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bvalid & m_bready;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid & m_rready;
    assign in_hs = in_valid & in_ready;

    // Counter holds words still to write; it is decremented only on a data-write response.
    assign last_write = (state == INIT_WR) ? (word_cnt == 8'd0) : (word_cnt == 8'd1);

`ifdef CRC_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_waiting, any_hs;

    assign tmo_waiting = (state == INIT_WR) || (state == DATA_WR) || (state == RES_RD);
    assign any_hs      = aw_hs | w_hs | b_hs | ar_hs | r_hs;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            word_cnt  <= '0;
            job_busy  <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_crc   <= '0;
            res_resp  <= '0;
            m_awvalid <= 1'b0;
            m_awaddr  <= '0;
            m_wvalid  <= 1'b0;
            m_wdata   <= '0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_rready  <= 1'b0;
`ifdef CRC_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (job_start) begin
                        word_cnt  <= job_len;
                        res_resp  <= '0;
                        job_busy  <= 1'b1;
                        m_awaddr  <= ADDR_CTRL;
                        m_wdata   <= INIT_VALUE;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        m_bready  <= 1'b1;
                        state     <= INIT_WR;
                    end
                end
                INIT_WR, DATA_WR: begin
                    if (aw_hs) m_awvalid <= 1'b0;
                    if (w_hs)  m_wvalid  <= 1'b0;
                    if (b_hs) begin
                        m_bready <= 1'b0;
                        res_resp <= res_resp | m_bresp;
                        if (state == DATA_WR) word_cnt <= word_cnt - 8'd1;
                        if (last_write) begin
                            m_araddr  <= ADDR_RES;
                            m_arvalid <= 1'b1;
                            m_rready  <= 1'b1;
                            state     <= RES_RD;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= DATA_GET;
                        end
                    end
                end
                DATA_GET: begin
                    if (in_hs) begin
                        in_ready  <= 1'b0;
                        m_wdata   <= in_data;
                        m_awaddr  <= ADDR_DATA;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        m_bready  <= 1'b1;
                        state     <= DATA_WR;
                    end
                end
                RES_RD: begin
                    if (ar_hs) m_arvalid <= 1'b0;
                    if (r_hs) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b0;
                        res_crc   <= m_rdata;
                        res_resp  <= res_resp | m_rresp;
                        res_valid <= 1'b1;
                        state     <= RES_OUT;
                    end
                end
                RES_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef CRC_SEQ_TIMEOUT_EN
            // Placed after the case so an expiry overrides whatever the state just scheduled.
            if (!tmo_waiting || any_hs) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == 8'hFF) begin
                tmo_cnt   <= '0;
                m_awvalid <= 1'b0;
                m_wvalid  <= 1'b0;
                m_bready  <= 1'b0;
                m_arvalid <= 1'b0;
                m_rready  <= 1'b0;
                res_resp  <= 2'b11;
                res_crc   <= '0;
                res_valid <= 1'b1;
                state     <= RES_OUT;
            end else begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_crc_job_sequencer.sv
// Scoreboard bench for crc_job_sequencer: a behavioural AXI-Lite slave, a requester feeding data words,
// and a result monitor. Expected AXI operations and results are queued at job issue and popped by the monitors.
module tb_crc_job_sequencer;

    logic        ACLK, ARESETn;
    logic        job_start, job_busy, in_valid, in_ready, res_valid, res_ready;
    logic [7:0]  job_len;
    logic [31:0] in_data, res_crc;
    logic [1:0]  res_resp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [7:0]  m_awaddr, m_araddr;
    logic [31:0] m_wdata, m_rdata;
    logic [1:0]  m_bresp, m_rresp;

    crc_job_sequencer #(.ADDR_WIDTH(8), .INIT_VALUE(32'hFFFF_FFFF)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .job_start(job_start), .job_len(job_len), .job_busy(job_busy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .res_valid(res_valid), .res_crc(res_crc), .res_resp(res_resp), .res_ready(res_ready),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] data;
    } op_t;

    op_t         exp_ops[$];
    logic [33:0] exp_res[$];
    logic [31:0] in_q[$];
    logic [31:0] job_words[$];
    logic [1:0]  b_q[$];

    int          checks = 0;
    int          failures = 0;
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          in_toggle = 0;
    logic [31:0] rd_val = '0;
    int          res_done = 0, acc_cnt = 0;
    int          pend_base = 0, pend_target = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // AXI-Lite slave: readies are chosen first, then the handshakes due at the coming edge are recorded.
    initial begin
        bit          aw_got, w_got, ar_got, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_pend, w_pend;
        logic [7:0]  cap_awaddr, cap_araddr, pend_awaddr;
        logic [31:0] cap_wdata, pend_wdata;
        int          aw_c, w_c, ar_c;
        op_t         e, act;
        aw_got = 0; w_got = 0; ar_got = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_pend = 0; w_pend = 0; cap_awaddr = '0; cap_araddr = '0; pend_awaddr = '0;
        cap_wdata = '0; pend_wdata = '0; aw_c = 0; w_c = 0; ar_c = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
        forever begin
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                aw_got = 0; w_got = 0; ar_got = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_pend = 0; w_pend = 0; aw_c = 0; w_c = 0; ar_c = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
            end else begin
                if (aw_pend && !aw_hs) chk("aw_hold", {m_awvalid, m_awaddr}, {1'b1, pend_awaddr});
                if (w_pend && !w_hs)   chk("w_hold", {m_wvalid, m_wdata}, {1'b1, pend_wdata});
                if (aw_hs) aw_got = 1;
                if (w_hs)  w_got = 1;
                if (b_hs) begin
                    m_bvalid = 0;
                    act = {1'b0, cap_awaddr, cap_wdata};
                    if (exp_ops.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write: got %h required none", act);
                    end else begin
                        e = exp_ops.pop_front();
                        chk("write_op", act, e);
                    end
                    aw_got = 0; w_got = 0;
                end
                if (ar_hs) begin
                    ar_got = 1;
                    act = {1'b1, cap_araddr, 32'h0};
                    if (exp_ops.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_read: got %h required none", act);
                    end else begin
                        e = exp_ops.pop_front();
                        chk("read_op", act, e);
                    end
                end
                if (r_hs) begin
                    m_rvalid = 0;
                    ar_got = 0;
                end
                if (m_awvalid && !aw_got) begin m_awready = (aw_c >= aw_delay); aw_c++; end
                else begin m_awready = 0; aw_c = 0; end
                if (m_wvalid && !w_got) begin m_wready = (w_c >= w_delay); w_c++; end
                else begin m_wready = 0; w_c = 0; end
                if (m_arvalid && !ar_got) begin m_arready = (ar_c >= ar_delay); ar_c++; end
                else begin m_arready = 0; ar_c = 0; end
                if (aw_got && w_got && !m_bvalid) begin
                    m_bvalid = 1;
                    m_bresp  = (b_q.size() > 0) ? b_q.pop_front() : 2'b00;
                end
                if (ar_got && !m_rvalid) begin
                    m_rvalid = 1;
                    m_rdata  = rd_val;
                    m_rresp  = 2'b00;
                end
                aw_hs = m_awvalid && m_awready;
                if (aw_hs) cap_awaddr = m_awaddr;
                w_hs = m_wvalid && m_wready;
                if (w_hs) cap_wdata = m_wdata;
                b_hs  = m_bvalid && m_bready;
                ar_hs = m_arvalid && m_arready;
                if (ar_hs) cap_araddr = m_araddr;
                r_hs  = m_rvalid && m_rready;
                aw_pend = m_awvalid && !aw_hs; pend_awaddr = m_awaddr;
                w_pend  = m_wvalid && !w_hs;   pend_wdata  = m_wdata;
            end
        end
    end

    // Requester: offers queued words, optionally only every other cycle.
    initial begin
        bit in_hs;
        int cyc;
        in_hs = 0; cyc = 0;
        in_valid = 0; in_data = '0;
        forever begin
            @(posedge ACLK); #1;
            cyc++;
            if (!ARESETn) begin
                in_valid = 0;
                in_hs = 0;
            end else begin
                if (in_hs) begin
                    if (in_q.size() > 0) in_q.delete(0);
                    acc_cnt++;
                end
                if (in_q.size() > 0 && (!in_toggle || cyc[0])) begin
                    in_valid = 1;
                    in_data  = in_q[0];
                end else begin
                    in_valid = 0;
                end
                in_hs = in_valid && in_ready;
            end
        end
    end

    // Result monitor: accepts each result two cycles after it appears.
    initial begin
        bit          res_hs, holding;
        int          rv_c;
        logic [31:0] hold_crc;
        logic [1:0]  hold_resp;
        logic [33:0] e;
        res_hs = 0; holding = 0; rv_c = 0; hold_crc = '0; hold_resp = '0;
        res_ready = 0;
        forever begin
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                res_ready = 0; res_hs = 0; holding = 0; rv_c = 0;
            end else begin
                if (res_hs) begin
                    chk("busy_drop", {31'h0, job_busy}, 0);
                    if (exp_res.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_result: got %h required none", {hold_crc, hold_resp});
                    end else begin
                        e = exp_res.pop_front();
                        chk("res_crc", hold_crc, e[33:2]);
                        chk("res_resp", hold_resp, e[1:0]);
                    end
                    res_done++;
                end else if (holding) begin
                    chk("res_hold", {res_valid, res_crc, res_resp}, {1'b1, hold_crc, hold_resp});
                end
                if (res_valid) begin res_ready = (rv_c >= 2); rv_c++; end
                else begin res_ready = 0; rv_c = 0; end
                res_hs    = res_valid && res_ready;
                holding   = res_valid && !res_hs;
                hold_crc  = res_crc;
                hold_resp = res_resp;
            end
        end
    end

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (res_done < target && n < 3000) begin
            @(posedge ACLK); #2;
            n++;
        end
        chk("job_done", res_done, target);
    endtask

    task automatic run_job(input logic [7:0] len, input logic [31:0] rdata, input logic [1:0] resp,
                           input bit exp_read, input bit do_wait);
        int n;
        n = 0;
        while (job_busy && n < 3000) begin
            @(posedge ACLK); #2;
            n++;
        end
        chk("idle_before_start", {31'h0, job_busy}, 0);
        exp_ops.push_back({1'b0, 8'h00, 32'hFFFF_FFFF});
        for (int i = 0; i < int'(len); i++) begin
            exp_ops.push_back({1'b0, 8'h04, job_words[i]});
            in_q.push_back(job_words[i]);
        end
        if (exp_read) exp_ops.push_back({1'b1, 8'h08, 32'h0});
        exp_res.push_back({rdata, resp});
        rd_val      = rdata;
        pend_base   = acc_cnt;
        pend_target = res_done + 1;
        job_len   = len;
        job_start = 1;
        @(posedge ACLK); #2;
        job_start = 0;
        job_len   = '0;
        chk("busy_set", {31'h0, job_busy}, 1);
        if (do_wait) begin
            wait_done(pend_target);
            chk("words_accepted", acc_cnt - pend_base, len);
        end
    endtask

    initial begin
        #800000;
        failures++;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        ARESETn = 0; job_start = 0; job_len = '0;
        repeat (3) @(posedge ACLK);
        #2 ARESETn = 1;
        @(posedge ACLK); #2;
        chk("reset_outputs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, in_ready,
                              job_busy, res_valid, res_resp, res_crc}, 0);

        job_words = '{32'h1234_5678};
        run_job(8'd1, 32'hCAFE_F00D, 2'b00, 1, 1);

        job_words.delete();
        run_job(8'd0, 32'h0BAD_BEEF, 2'b00, 1, 1);

        aw_delay = 3; in_toggle = 1;
        job_words = '{32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 32'hA4A4_0004};
        run_job(8'd4, 32'h89AB_CDEF, 2'b00, 1, 1);
        aw_delay = 0; in_toggle = 0;

        job_words = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
        b_q = '{2'b00, 2'b00, 2'b10, 2'b00};
        run_job(8'd3, 32'h5555_AAAA, 2'b10, 1, 1);

        // A second start request mid-job must leave the running job untouched.
        job_words = '{32'hBEEF_0001, 32'hBEEF_0002};
        run_job(8'd2, 32'h0000_0001, 2'b00, 1, 0);
        repeat (3) @(posedge ACLK);
        #2 job_start = 1; job_len = 8'd7;
        @(posedge ACLK); #2;
        job_start = 0; job_len = '0;
        wait_done(pend_target);
        chk("words_accepted_busy", acc_cnt - pend_base, 2);

        job_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        run_job(8'd3, 32'hDEAD_0000, 2'b00, 1, 0);
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge ACLK); #2;
            if (m_awvalid && m_awaddr == 8'h04) found = 1;
        end
        chk("reach_data_wr", {31'h0, found}, 1);
        #1 ARESETn = 0;
        #1;
        chk("async_reset_outputs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, in_ready,
                                    job_busy, res_valid, res_resp, res_crc}, 0);
        exp_ops.delete(); exp_res.delete(); in_q.delete(); b_q.delete();
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1;
        @(posedge ACLK); #2;

        job_words = '{32'h0F0F_0F0F};
        run_job(8'd1, 32'h1357_9BDF, 2'b00, 1, 1);

`ifdef CRC_SEQ_TIMEOUT_EN
        ar_delay = 100000;
        job_words.delete();
        run_job(8'd0, 32'h0000_0000, 2'b11, 0, 1);
        ar_delay = 0;
`else
        ar_delay = 300;
        job_words.delete();
        run_job(8'd0, 32'h2468_ACE0, 2'b00, 1, 1);
        ar_delay = 0;
`endif

        repeat (5) @(posedge ACLK); #2;
        chk("ops_drained", exp_ops.size(), 0);
        chk("results_drained", exp_res.size(), 0);
        chk("words_drained", in_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_job_sequencer.md
CRC_JOB_SEQUENCER -- requirements
Module: crc_job_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, AXI-Lite master address width.
REQ-002 SHALL have parameter INIT_VALUE, default 32'hFFFF_FFFF, word written to CRC control register at job start.
REQ-003 ACLK  input  1  sole clock; all logic on rising edge.
REQ-004 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 job_start  input  1  pulse requesting a new CRC job; sampled only when job_busy=0.
REQ-006 job_len  input  8  number of data words in job, captured with job_start; 0 legal.
REQ-007 job_busy  output  1  high from accepted job_start until result handshake.
REQ-008 in_valid  input  1  data word valid from requester.
REQ-009 in_data  input  32  data word.
REQ-010 in_ready  output  1  word accepted when in_valid & in_ready.
REQ-011 res_valid  output  1  result available.
REQ-012 res_crc  output  32  CRC read back from result register.
REQ-013 res_resp  output  2  worst AXI response seen during job (OKAY=00, SLVERR=10, timeout=11).
REQ-014 res_ready  input  1  requester accepts result.
REQ-015 m_awvalid/m_awready (1 out/1 in), m_awaddr (ADDR_WIDTH out): AXI-Lite write address channel.
REQ-016 m_wvalid/m_wready (1 out/1 in), m_wdata (32 out): AXI-Lite write data channel.
REQ-017 m_bvalid (1 in), m_bresp (2 in), m_bready (1 out): write response channel.
REQ-018 m_arvalid/m_arready (1 out/1 in), m_araddr (ADDR_WIDTH out): read address channel.
REQ-019 m_rvalid (1 in), m_rdata (32 in), m_rresp (2 in), m_rready (1 out): read data channel.

Function
REQ-020 FSM states SHALL be IDLE, INIT_WR, DATA_GET, DATA_WR, RES_RD, RES_OUT.
REQ-021 IDLE: job_start SHALL latch job_len into word counter, clear res_resp, go INIT_WR next cycle; job_start while busy SHALL be ignored.
REQ-022 Every write SHALL assert m_awvalid and m_wvalid in the same cycle, drop each independently on its own handshake, hold m_bready high, and complete on m_bvalid.
REQ-023 INIT_WR SHALL write INIT_VALUE to address 0x00; on B: counter 0 -> RES_RD, else DATA_GET.
REQ-024 DATA_GET SHALL assert in_ready for exactly the accepting cycle, register in_data, go DATA_WR; in_ready SHALL be 0 in all other states.
REQ-025 DATA_WR SHALL write the registered word to 0x04; on B decrement counter; counter reaching 0 -> RES_RD, else DATA_GET.
REQ-026 RES_RD SHALL assert m_arvalid with address 0x08 until m_arready, m_rready high; on m_rvalid capture m_rdata into res_crc, go RES_OUT.
REQ-027 Any bresp/rresp nonzero SHALL OR into res_resp (sticky); job continues to completion.
REQ-028 RES_OUT SHALL hold res_valid and res_crc stable until res_ready, then return IDLE; job_busy drops same edge.
REQ-029 AXI valids SHALL never drop before handshake; addresses and data SHALL be stable while valid.

Reset
REQ-030 On ARESETn low, SHALL asynchronously force IDLE; all valids, in_ready, m_bready, m_rready, job_busy, res_valid = 0; res_crc = 0, res_resp = 00, counter = 0; any in-flight job SHALL be dropped without result.

Configuration
REQ-031 With CRC_SEQ_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles in any state awaiting an AXI handshake; at 255 it SHALL drop all AXI valids/readies, set res_resp=11, res_crc=0, go RES_OUT; counter clears on every handshake.
REQ-032 Without CRC_SEQ_TIMEOUT_EN, no timeout logic SHALL exist; sequencer waits indefinitely and res_resp never equals 11.

Verification
REQ-033 job_len=1, word 32'h1234_5678, slave OKAY -> writes (0x00,FFFFFFFF),(0x04,12345678), read 0x08; res_crc = slave value, res_resp=00.
REQ-034 job_len=0 -> one write to 0x00 then read 0x08, in_ready never asserted, res_valid one job later.
REQ-035 job_len=4, in_valid toggling and m_awready delayed 3 cycles vs m_wready -> exactly 4 data writes in order, valids held until handshake.
REQ-036 Slave returns bresp=10 on second data write of job_len=3 -> job completes, res_resp=10; next job res_resp=00.
REQ-037 ARESETn pulsed low during DATA_WR -> all outputs reset values immediately; new job after reset completes normally.
REQ-038 CRC_SEQ_TIMEOUT_EN defined, m_arready held 0 -> res_valid after 255 waiting cycles, res_resp=11, res_crc=0.
